// File: rtl/axi_latency_fifo_if.sv
// Stream interface for the latency-balancing delay line.
// The slave modport is the block's view; master is the source/consumer side.
interface axi_latency_fifo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] s_axis_a_tdata;
  logic             s_axis_a_tvalid;
  logic             s_axis_a_tready;
  logic [WIDTH-1:0] m_axis_result_tdata;
  logic             m_axis_result_tvalid;
  logic             m_axis_result_tready;

  modport master (
    output s_axis_a_tdata, s_axis_a_tvalid, m_axis_result_tready,
    input  s_axis_a_tready, m_axis_result_tdata, m_axis_result_tvalid
  );

  modport slave (
    input  s_axis_a_tdata, s_axis_a_tvalid, m_axis_result_tready,
    output s_axis_a_tready, m_axis_result_tdata, m_axis_result_tvalid
  );
endinterface

// File: rtl/axi_latency_fifo.sv
// Fixed-latency stream delay line feeding a first-word-fall-through FIFO.
// Input credit is taken from the registered total of beats in flight plus buffered.
module axi_latency_fifo #(
  parameter int  WIDTH   = 32,
  parameter int  LATENCY = 8,
  parameter int  DEPTH   = 16,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_latency_fifo_if.slave axis,
  output logic [CNT_W-1:0]  occupancy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (LATENCY < 1 || DEPTH < 1) begin : g_param_check
      $error("axi_latency_fifo: LATENCY and DEPTH must both be at least 1");
    end
  endgenerate

  logic             dl_vld_q [LATENCY];
  logic             dl_vld_d [LATENCY];
  logic [WIDTH-1:0] dl_dat_q [LATENCY];
  logic [WIDTH-1:0] dl_dat_d [LATENCY];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  logic s_ready;
  logic accept;
  logic exit_vld;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    s_ready  = occ_q < CNT_W'(DEPTH);
    accept   = axis.s_axis_a_tvalid && s_ready;
    exit_vld = dl_vld_q[LATENCY-1];
    pop      = (fifo_cnt_q != '0) && axis.m_axis_result_tready;

    // Delay line never stalls; the credit limit guarantees the FIFO has room at exit.
    dl_vld_d[0] = accept;
    dl_dat_d[0] = axis.s_axis_a_tdata;
    for (int i = 1; i < LATENCY; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_dat_d[i] = dl_dat_q[i-1];
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (exit_vld) begin
      mem_d[wr_ptr_q] = dl_dat_q[LATENCY-1];
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    fifo_cnt_d = fifo_cnt_q;
    if (exit_vld && !pop) fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!exit_vld && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);

    occ_d = occ_q;
    if (accept && !pop) occ_d = occ_q + CNT_W'(1);
    else if (!accept && pop) occ_d = occ_q - CNT_W'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < LATENCY; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_dat_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      occ_q      <= '0;
    end else begin
      dl_vld_q   <= dl_vld_d;
      dl_dat_q   <= dl_dat_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      occ_q      <= occ_d;
    end
  end

  // Head slot is never overwritten while occupied, so held data stays stable under stall.
  assign axis.s_axis_a_tready      = s_ready;
  assign axis.m_axis_result_tvalid = (fifo_cnt_q != '0);
  assign axis.m_axis_result_tdata  = mem_q[rd_ptr_q];
  assign occupancy                 = occ_q;
endmodule

// File: tb/tb_axi_latency_fifo.sv
// Randomized bench for axi_latency_fifo against a queue-based timing model.
// A second instance with one extra slot of depth exercises sustained throughput.
module tb_axi_latency_fifo;
  localparam int W  = 32;
  localparam int L  = 3;
  localparam int D  = 4;
  localparam int D2 = 5;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [2:0] occ;
  logic [2:0] occ_tp;

  axi_latency_fifo_if #(.WIDTH(W)) bus ();
  axi_latency_fifo_if #(.WIDTH(W)) tp ();

  axi_latency_fifo #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
    .aclk(aclk), .aresetn(aresetn), .axis(bus), .occupancy(occ)
  );

  axi_latency_fifo #(.WIDTH(W), .LATENCY(L), .DEPTH(D2)) dut_tp (
    .aclk(aclk), .aresetn(aresetn), .axis(tp), .occupancy(occ_tp)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Model: each accepted beat becomes visible LATENCY edges after its accept edge.
  typedef struct {
    logic [W-1:0] d;
    int           vis;
  } beat_t;
  beat_t mq[$];
  int    edge_n = 0;

  function automatic bit exp_mv();
    if (mq.size() == 0) return 1'b0;
    return mq[0].vis <= edge_n;
  endfunction

  function automatic bit exp_sr();
    return mq.size() < D;
  endfunction

  task automatic model_edge(input bit sv, input logic [W-1:0] sd, input bit mr);
    bit p, a;
    p = exp_mv() && mr;
    a = sv && exp_sr();
    edge_n++;
    if (p) void'(mq.pop_front());
    if (a) mq.push_back('{d: sd, vis: edge_n + L});
  endtask

  task automatic drive(input bit sv, input logic [W-1:0] sd, input bit mr);
    bus.s_axis_a_tvalid      = sv;
    bus.s_axis_a_tdata       = sd;
    bus.m_axis_result_tready = mr;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0);
    tp.s_axis_a_tvalid = 1'b0;
    tp.s_axis_a_tdata = '0;
    tp.m_axis_result_tready = 1'b0;
    #1;
    checks += 4;
    if (bus.s_axis_a_tready !== 1'b1) begin errors++; $display("FAIL reset_in_tready got %0b want 1", bus.s_axis_a_tready); end
    if (bus.m_axis_result_tvalid !== 1'b0) begin errors++; $display("FAIL reset_in_tvalid got %0b want 0", bus.m_axis_result_tvalid); end
    if (occ !== 3'd0) begin errors++; $display("FAIL reset_in_occ got %0d want 0", occ); end
    if (bus.m_axis_result_tdata !== 32'h0) begin errors++; $display("FAIL reset_in_tdata got %h want 0", bus.m_axis_result_tdata); end
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      checks += 3;
      if (bus.s_axis_a_tready !== 1'b1) begin errors++; $display("FAIL reset_tready cyc %0d got %0b want 1", c, bus.s_axis_a_tready); end
      if (bus.m_axis_result_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid cyc %0d got %0b want 0", c, bus.m_axis_result_tvalid); end
      if (occ !== 3'd0) begin errors++; $display("FAIL reset_occ cyc %0d got %0d want 0", c, occ); end
      drive(1'b0, '0, 1'b0);
      model_edge(1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_single();
    int seen_cyc;
    seen_cyc = -1;
    for (int c = 0; c < 9; c++) begin
      @(negedge aclk);
      checks += 3;
      if (bus.m_axis_result_tvalid !== exp_mv()) begin errors++; $display("FAIL single_tvalid cyc %0d got %0b want %0b", c, bus.m_axis_result_tvalid, exp_mv()); end
      if (occ !== 3'(mq.size())) begin errors++; $display("FAIL single_occ cyc %0d got %0d want %0d", c, occ, mq.size()); end
      if (bus.s_axis_a_tready !== exp_sr()) begin errors++; $display("FAIL single_tready cyc %0d got %0b want %0b", c, bus.s_axis_a_tready, exp_sr()); end
      if (exp_mv()) begin
        checks++;
        if (bus.m_axis_result_tdata !== mq[0].d) begin errors++; $display("FAIL single_tdata got %h want %h", bus.m_axis_result_tdata, mq[0].d); end
      end
      if (bus.m_axis_result_tvalid === 1'b1 && seen_cyc < 0) seen_cyc = c;
      drive(c == 0, 32'h3F80_0000, 1'b1);
      model_edge(c == 0, 32'h3F80_0000, 1'b1);
    end
    // Accept edge is the one after c=0; valid is seen in the cycle after that edge + L.
    checks++;
    if (seen_cyc != L + 1) begin errors++; $display("FAIL single_first_valid_cycle got %0d want %0d", seen_cyc, L + 1); end
  endtask

  task automatic test_stream();
    logic [W-1:0] got[$];
    int nxt;
    bit sv;
    nxt = 1;
    for (int c = 0; c < 45; c++) begin
      @(negedge aclk);
      checks += 3;
      if (bus.m_axis_result_tvalid !== exp_mv()) begin errors++; $display("FAIL stream_tvalid cyc %0d got %0b want %0b", c, bus.m_axis_result_tvalid, exp_mv()); end
      if (occ !== 3'(mq.size())) begin errors++; $display("FAIL stream_occ cyc %0d got %0d want %0d", c, occ, mq.size()); end
      if (bus.s_axis_a_tready !== exp_sr()) begin errors++; $display("FAIL stream_tready cyc %0d got %0b want %0b", c, bus.s_axis_a_tready, exp_sr()); end
      if (exp_mv()) begin
        checks++;
        if (bus.m_axis_result_tdata !== mq[0].d) begin errors++; $display("FAIL stream_tdata got %h want %h", bus.m_axis_result_tdata, mq[0].d); end
      end
      sv = (nxt <= 20);
      drive(sv, W'(nxt), 1'b1);
      if (bus.m_axis_result_tvalid === 1'b1) got.push_back(bus.m_axis_result_tdata);
      if (sv && exp_sr()) begin
        model_edge(sv, W'(nxt), 1'b1);
        nxt++;
      end else begin
        model_edge(sv, W'(nxt), 1'b1);
      end
    end
    checks++;
    if (got.size() != 20) begin errors++; $display("FAIL stream_count got %0d want 20", got.size()); end
    for (int k = 0; k < got.size() && k < 20; k++) begin
      checks++;
      if (got[k] !== W'(k + 1)) begin errors++; $display("FAIL stream_order idx %0d got %0d want %0d", k, got[k], k + 1); end
    end
  endtask

  task automatic test_backpressure();
    int nxt;
    int acc_cnt;
    bit mr;
    nxt = 32'hA0;
    acc_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge aclk);
      checks += 3;
      if (bus.m_axis_result_tvalid !== exp_mv()) begin errors++; $display("FAIL bp_tvalid cyc %0d got %0b want %0b", c, bus.m_axis_result_tvalid, exp_mv()); end
      if (occ !== 3'(mq.size())) begin errors++; $display("FAIL bp_occ cyc %0d got %0d want %0d", c, occ, mq.size()); end
      if (bus.s_axis_a_tready !== exp_sr()) begin errors++; $display("FAIL bp_tready cyc %0d got %0b want %0b", c, bus.s_axis_a_tready, exp_sr()); end
      if (exp_mv()) begin
        checks++;
        if (bus.m_axis_result_tdata !== mq[0].d) begin errors++; $display("FAIL bp_tdata cyc %0d got %h want %h", c, bus.m_axis_result_tdata, mq[0].d); end
      end
      if (c == 12) begin
        checks += 3;
        if (acc_cnt != D) begin errors++; $display("FAIL bp_accepted got %0d want %0d", acc_cnt, D); end
        if (occ !== 3'(D)) begin errors++; $display("FAIL bp_full_occ got %0d want %0d", occ, D); end
        if (bus.m_axis_result_tdata !== 32'hA0) begin errors++; $display("FAIL bp_held_head got %h want a0", bus.m_axis_result_tdata); end
      end
      mr = (c >= 12);
      drive(c < 12, W'(nxt), mr);
      if (bus.s_axis_a_tvalid && bus.s_axis_a_tready) acc_cnt++;
      if ((c < 12) && exp_sr()) nxt++;
      model_edge(c < 12, W'(nxt - (((c < 12) && exp_sr()) ? 1 : 0)), mr);
    end
  endtask

  task automatic test_random();
    beat_t sb[$];
    int acc_n;
    int cyc;
    bit sv, mr;
    logic [W-1:0] sd;
    acc_n = 0;
    cyc = 0;
    while ((acc_n < 10000 || mq.size() != 0) && cyc < 60000) begin
      @(negedge aclk);
      checks += 4;
      if (bus.m_axis_result_tvalid !== exp_mv()) begin errors++; $display("FAIL rand_tvalid cyc %0d got %0b want %0b", cyc, bus.m_axis_result_tvalid, exp_mv()); end
      if (occ !== 3'(mq.size())) begin errors++; $display("FAIL rand_occ cyc %0d got %0d want %0d", cyc, occ, mq.size()); end
      if (bus.s_axis_a_tready !== exp_sr()) begin errors++; $display("FAIL rand_tready cyc %0d got %0b want %0b", cyc, bus.s_axis_a_tready, exp_sr()); end
      if (occ > 3'(D)) begin errors++; $display("FAIL rand_occ_bound cyc %0d got %0d want <=%0d", cyc, occ, D); end
      if (exp_mv()) begin
        checks++;
        if (bus.m_axis_result_tdata !== mq[0].d) begin errors++; $display("FAIL rand_tdata cyc %0d got %h want %h", cyc, bus.m_axis_result_tdata, mq[0].d); end
      end
      sv = (acc_n < 10000) && ($urandom_range(0, 99) < 60);
      mr = ($urandom_range(0, 99) < 70);
      sd = $urandom;
      drive(sv, sd, mr);
      if (bus.m_axis_result_tvalid === 1'b1 && mr) begin
        checks += 2;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_dup cyc %0d got %h want no beat", cyc, bus.m_axis_result_tdata);
        end else begin
          if (bus.m_axis_result_tdata !== sb[0].d) begin errors++; $display("FAIL rand_sb_data cyc %0d got %h want %h", cyc, bus.m_axis_result_tdata, sb[0].d); end
          if (edge_n + 1 - sb[0].vis < L) begin errors++; $display("FAIL rand_latency cyc %0d got %0d want >=%0d", cyc, edge_n + 1 - sb[0].vis, L); end
          void'(sb.pop_front());
        end
      end
      if (sv && bus.s_axis_a_tready === 1'b1) sb.push_back('{d: sd, vis: edge_n + 1});
      if (sv && exp_sr()) acc_n++;
      model_edge(sv, sd, mr);
      cyc++;
    end
    checks += 2;
    if (cyc >= 60000) begin errors++; $display("FAIL rand_timeout got %0d cycles want <60000", cyc); end
    if (sb.size() != 0) begin errors++; $display("FAIL rand_loss got %0d left want 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      drive(1'b1, W'(32'h55 + c), 1'b1);
      model_edge(1'b1, W'(32'h55 + c), 1'b1);
    end
    @(negedge aclk);
    drive(1'b0, '0, 1'b1);
    checks++;
    if (occ !== 3'd3) begin errors++; $display("FAIL arst_pre_occ got %0d want 3", occ); end
    #2 aresetn = 1'b0;
    #1;
    mq.delete();
    checks += 4;
    if (bus.m_axis_result_tvalid !== 1'b0) begin errors++; $display("FAIL arst_tvalid got %0b want 0", bus.m_axis_result_tvalid); end
    if (occ !== 3'd0) begin errors++; $display("FAIL arst_occ got %0d want 0", occ); end
    if (bus.s_axis_a_tready !== 1'b1) begin errors++; $display("FAIL arst_tready got %0b want 1", bus.s_axis_a_tready); end
    if (bus.m_axis_result_tdata !== 32'h0) begin errors++; $display("FAIL arst_tdata got %h want 0", bus.m_axis_result_tdata); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      checks += 2;
      if (bus.m_axis_result_tvalid !== 1'b0) begin errors++; $display("FAIL arst_stale cyc %0d got %0b want 0", c, bus.m_axis_result_tvalid); end
      if (occ !== 3'd0) begin errors++; $display("FAIL arst_post_occ cyc %0d got %0d want 0", c, occ); end
      drive(1'b0, '0, 1'b1);
      model_edge(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_throughput();
    int t, acc, popped;
    bit ev;
    for (int c = 0; c < 42; c++) begin
      @(negedge aclk);
      t = c - 1;
      acc = (t < 0) ? 0 : ((t > 29) ? 30 : t + 1);
      popped = (t - L < 0) ? 0 : ((t - L > 30) ? 30 : t - L);
      ev = (t >= L) && (t <= 29 + L);
      checks += 3;
      if (tp.s_axis_a_tready !== 1'b1) begin errors++; $display("FAIL tp_tready cyc %0d got %0b want 1", c, tp.s_axis_a_tready); end
      if (tp.m_axis_result_tvalid !== ev) begin errors++; $display("FAIL tp_tvalid cyc %0d got %0b want %0b", c, tp.m_axis_result_tvalid, ev); end
      if (occ_tp !== 3'(acc - popped)) begin errors++; $display("FAIL tp_occ cyc %0d got %0d want %0d", c, occ_tp, acc - popped); end
      if (ev) begin
        checks++;
        if (tp.m_axis_result_tdata !== W'(t - L + 1)) begin errors++; $display("FAIL tp_tdata cyc %0d got %0d want %0d", c, tp.m_axis_result_tdata, t - L + 1); end
      end
      tp.s_axis_a_tvalid = (c < 30);
      tp.s_axis_a_tdata = W'(c + 1);
      tp.m_axis_result_tready = 1'b1;
    end
    tp.s_axis_a_tvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random();
    test_async_reset();
    test_throughput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
